// File: rtl/branch_resolver_pkg.sv
// Shared types and default sizing for the branch resolver slice (package br_pkg).
package br_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RESOLVE
   } br_state_t;

   localparam int unsigned BR_FIFO_DEPTH = 4;
   localparam int unsigned BR_RES_DELAY  = 2;
   localparam int unsigned BR_CNT_W      = 16;

endpackage

// File: rtl/br_outcome_fifo.sv
// 1-bit synchronous FIFO buffering actual branch outcomes; async active-low reset.
module br_outcome_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push_i,
   input  logic din_i,
   input  logic pop_i,
   output logic dout_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] mem_q;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign dout_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Issues predict/train requests to a 2-bit predictor for buffered trace outcomes and scores them.
// Optional BR_RESOLVER_STREAK_EN adds the best_streak output (longest run of correct predictions).
module branch_resolver
   import br_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = BR_FIFO_DEPTH,
   parameter int unsigned RES_DELAY  = BR_RES_DELAY,
   parameter int unsigned CNT_W      = BR_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_valid,
   input  logic             br_taken,
   output logic             br_ready,
   output logic             request,
   input  logic             prediction,
   output logic             result,
   output logic             taken,
   output logic             resolve_valid,
   output logic             mispredict,
   output logic [CNT_W-1:0] total_cnt,
   output logic [CNT_W-1:0] miss_cnt,
`ifdef BR_RESOLVER_STREAK_EN
   output logic [CNT_W-1:0] best_streak,
`endif
   output logic             busy
);

   localparam int unsigned WCW = (RES_DELAY > 1) ? $clog2(RES_DELAY) : 1;

   br_state_t        state_q;
   logic [WCW-1:0]   wait_cnt_q;
   logic             cur_taken_q, pred_q, pred_d;
   logic             request_q, result_q, taken_q, mispredict_q;
   logic [CNT_W-1:0] total_q, miss_q;
   logic             fifo_dout, fifo_full, fifo_empty;

   br_outcome_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (br_valid),
      .din_i   (br_taken),
      .pop_i   (state_q == IDLE),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // The prediction is sampled in the first WAIT cycle; bypass it so RES_DELAY=1 still scores correctly.
   always_comb begin
      pred_d = pred_q;
      if (state_q == WAIT && wait_cnt_q == '0) pred_d = prediction;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wait_cnt_q   <= '0;
         cur_taken_q  <= 1'b0;
         pred_q       <= 1'b0;
         request_q    <= 1'b0;
         result_q     <= 1'b0;
         taken_q      <= 1'b0;
         mispredict_q <= 1'b0;
      end else begin
         request_q    <= 1'b0;
         result_q     <= 1'b0;
         taken_q      <= 1'b0;
         mispredict_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  cur_taken_q <= fifo_dout;
                  request_q   <= 1'b1;
                  state_q     <= REQ;
               end
            end
            REQ: begin
               wait_cnt_q <= '0;
               state_q    <= WAIT;
            end
            WAIT: begin
               pred_q <= pred_d;
               if (wait_cnt_q == WCW'(RES_DELAY - 1)) begin
                  result_q     <= 1'b1;
                  taken_q      <= cur_taken_q;
                  mispredict_q <= pred_d ^ cur_taken_q;
                  state_q      <= RESOLVE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            RESOLVE: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_q <= '0;
         miss_q  <= '0;
      end else if (result_q) begin
         if (total_q != '1) total_q <= total_q + 1'b1;
         if (mispredict_q && miss_q != '1) miss_q <= miss_q + 1'b1;
      end
   end

`ifdef BR_RESOLVER_STREAK_EN
   logic [CNT_W-1:0] cur_streak_q, cur_streak_d, best_streak_q;

   always_comb begin
      cur_streak_d = cur_streak_q;
      if (mispredict_q) cur_streak_d = '0;
      else if (cur_streak_q != '1) cur_streak_d = cur_streak_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_streak_q  <= '0;
         best_streak_q <= '0;
      end else if (result_q) begin
         cur_streak_q <= cur_streak_d;
         if (cur_streak_d > best_streak_q) best_streak_q <= cur_streak_d;
      end
   end

   assign best_streak = best_streak_q;
`endif

   assign br_ready      = !fifo_full;
   assign request       = request_q;
   assign result        = result_q;
   assign resolve_valid = result_q;
   assign taken         = taken_q;
   assign mispredict    = mispredict_q;
   assign total_cnt     = total_q;
   assign miss_cnt      = miss_q;
   assign busy          = (state_q != IDLE) || !fifo_empty;

endmodule
